ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, Clk cycles the clock line is held low before the start bit (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, Clk cycles of device-clock inactivity that abort a frame (15 ms at 50 MHz).
REQ-003 Clk  input  1  system clock, 50 MHz.
REQ-004 Reset  input  1  asynchronous, active-low reset; block is reset while 0.
REQ-005 send  input  1  one-cycle request to transmit tx_byte; sampled only in IDLE.
REQ-006 tx_byte  input  8  command byte; captured on the accepted send cycle.
REQ-007 psClk_in, psData_in  input  1 each  raw PS/2 line levels, asynchronous.
REQ-008 psClk_oe, psData_oe  output  1 each  1 = drive line low; 0 = release (open drain).
REQ-009 busy  output  1  high from the accepted send through the end of the frame.
REQ-010 done  output  1  one-cycle pulse when a frame completes with a valid ack.
REQ-011 ack_err  output  1  one-cycle pulse when a frame ends without an ack, or on timeout.

Function
REQ-012 psClk_in and psData_in each pass through a 2-flop synchronizer; a device-clock falling edge is synchronized previous=1 and current=0.
REQ-013 States: IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE.
REQ-014 IDLE: outputs released and busy=0; send=1 latches tx_byte and computes odd parity (parity = ~^tx_byte); next cycle INHIBIT and busy=1.
REQ-015 INHIBIT: psClk_oe=1 for INHIBIT_CYCLES; on the last cycle psData_oe goes to 1 (start bit 0); next state START.
REQ-016 START: psClk_oe=0 and psData_oe=1; bit counter cleared; go to SHIFT.
REQ-017 SHIFT, per device falling edge n (1-based): n=1..8 put data bit n-1 (LSB first), n=9 parity, n=10 stop (line released); psData_oe = ~bit, updated in the cycle after the edge is detected.
REQ-018 After the 10th falling edge go to ACK; on the 11th falling edge sample synchronized data: 0 gives done, 1 gives ack_err; then WAIT_IDLE.
REQ-019 WAIT_IDLE: all outputs released; return to IDLE once synchronized clock and data are both 1; busy stays 1 until then.
REQ-020 done and ack_err are never asserted in the same cycle and each lasts exactly one Clk.
REQ-021 send while busy=1 is ignored; no queuing.
REQ-022 Edge counter is 4 bits, saturates at 11, and never wraps.
REQ-023 Device-clock edges seen in IDLE, INHIBIT or WAIT_IDLE are ignored.

Reset
REQ-024 Reset=0 immediately forces IDLE, psClk_oe=0, psData_oe=0, busy=0, done=0, ack_err=0, clears all counters and synchronizers to 1 (idle line).
REQ-025 Reset asserted mid-frame abandons the frame with no done/ack_err pulse; the lines are released at once.

Configuration
REQ-026 Macro PS2_TX_TIMEOUT_EN defined: in START, SHIFT or ACK, a counter reset on every device falling edge reaches TIMEOUT_CYCLES, which pulses ack_err, releases both lines and enters WAIT_IDLE.
REQ-027 PS2_TX_TIMEOUT_EN undefined: no timeout counter is built; the block waits indefinitely for device clocks.

Verification
REQ-028 send with tx_byte=0xED, device model acks -> bits 1,0,1,1,0,1,1,1, parity 1, stop 1 on edges 1-10; done pulse once; busy drops after lines idle.
REQ-029 tx_byte=0x00 -> parity bit 1; tx_byte=0x01 -> parity bit 0.
REQ-030 Device leaves data high at the 11th edge -> one ack_err pulse, no done.
REQ-031 send asserted during SHIFT with a different byte -> ignored; the original byte completes unchanged.
REQ-032 With PS2_TX_TIMEOUT_EN and the device stopping after 4 edges -> ack_err exactly TIMEOUT_CYCLES after the 4th edge, both oe=0.
REQ-033 Reset pulled low at edge 6 -> oe outputs 0 within the same cycle, busy=0, no pulses; the next send transmits normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
//
// Sends one command byte to a PS/2 device: inhibits the clock line, issues a
// start bit, shifts 8 data bits LSB first, odd parity and a stop bit on the
// device's falling clock edges, then samples the device acknowledge bit.
// Lines are open drain: an *_oe output of 1 pulls the line low.
//
// Optional build macro:
//   PS2_TX_TIMEOUT_EN - when defined, a stalled device clock (no falling edge
//                       for TIMEOUT_CYCLES while in START/SHIFT/ACK) aborts
//                       the frame with an ack_err pulse. When undefined the
//                       block waits indefinitely and no timeout counter exists.
//
// Handshake: a one-cycle send pulse is accepted only while busy=0; busy rises
// the next cycle and stays high until both lines are idle again after the
// frame. Exactly one of done/ack_err pulses for one cycle per finished frame;
// a reset abandons the frame silently.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       send,
    input  logic [7:0] tx_byte,
    input  logic       psClk_in,
    input  logic       psData_in,
    output logic       psClk_oe,
    output logic       psData_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    localparam int              INH_W     = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [3:0]      EDGE_MAX  = 4'd11;
    localparam logic [3:0]      EDGE_STOP = 4'd9;   // count before the stop-bit edge

    // Reject parameter values the counters cannot represent meaningfully.
    if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("ps2_host_tx: INHIBIT_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    // ------------------------------------------------------------------
    // State and datapath flops
    // ------------------------------------------------------------------
    state_t           state_q, state_d;

    logic             clk_s1_q, clk_s1_d;
    logic             clk_s2_q, clk_s2_d;
    logic             clk_prev_q, clk_prev_d;
    logic             data_s1_q, data_s1_d;
    logic             data_s2_q, data_s2_d;

    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [3:0]       edge_cnt_q, edge_cnt_d;
    logic [9:0]       frame_q, frame_d;     // {stop, parity, data[7:0]}, bit 0 goes next
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;

    logic             fall;
    logic             inhibit_last;
    logic             timeout_hit;
    logic [3:0]       edge_cnt_inc;

    // Device clock falling edge as seen through the synchronizer.
    assign fall         = clk_prev_q & ~clk_s2_q;
    assign inhibit_last = (state_q == ST_INHIBIT) && (inh_cnt_q == INH_LAST);
    assign edge_cnt_inc = (edge_cnt_q == EDGE_MAX) ? edge_cnt_q : edge_cnt_q + 4'd1;

    // ------------------------------------------------------------------
    // Optional device-clock stall timeout
    // ------------------------------------------------------------------
`ifdef PS2_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            in_frame;

    // Count cycles since the last falling edge (the edge cycle counts as one),
    // so the abort lands TIMEOUT_CYCLES after the synchronized edge.
    always_comb begin
        in_frame    = (state_q == ST_START) || (state_q == ST_SHIFT) || (state_q == ST_ACK);
        to_cnt_d    = '0;
        if (in_frame) begin
            to_cnt_d = fall ? TO_W'(1) : to_cnt_q + TO_W'(1);
        end
        timeout_hit = in_frame && !fall && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    end

    // Timeout counter register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Two-flop synchronizers plus edge-history flop for the device clock
    // ------------------------------------------------------------------
    // Next values of the synchronizer chain.
    always_comb begin
        clk_s1_d   = psClk_in;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        data_s1_d  = psData_in;
        data_s2_d  = data_s1_q;
    end

    // Synchronizer registers; reset to the idle (high) line level.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            clk_prev_q <= clk_prev_d;
            data_s1_q  <= data_s1_d;
            data_s2_q  <= data_s2_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic. Falling edges only matter in START/SHIFT/ACK.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (send) state_d = ST_INHIBIT;
            ST_INHIBIT:   if (inhibit_last) state_d = ST_START;
            ST_START:     state_d = ST_SHIFT;
            ST_SHIFT:     if (fall && (edge_cnt_q == EDGE_STOP)) state_d = ST_ACK;
            ST_ACK:       if (fall) state_d = ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (clk_s2_q && data_s2_q) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        if (timeout_hit) begin
            state_d = ST_WAIT_IDLE;
        end
    end

    // FSM: outputs. Lines are driven straight from state so reset releases them at once.
    always_comb begin
        psClk_oe  = 1'b0;
        psData_oe = 1'b0;
        case (state_q)
            ST_INHIBIT: begin
                psClk_oe  = 1'b1;
                psData_oe = inhibit_last;   // start bit pulled low on the final inhibit cycle
            end
            ST_START:   psData_oe = 1'b1;
            ST_SHIFT:   psData_oe = data_oe_q;
            ST_ACK:     psData_oe = data_oe_q;
            default: begin
                psClk_oe  = 1'b0;
                psData_oe = 1'b0;
            end
        endcase
        busy      = (state_q != ST_IDLE);
        done      = done_q;
        ack_err   = ack_err_q;
        state_dbg = state_q;
    end

    // ------------------------------------------------------------------
    // Datapath: inhibit timer, edge counter, frame shifter, ack sampling
    // ------------------------------------------------------------------
    // Datapath next-state logic.
    always_comb begin
        inh_cnt_d  = '0;
        edge_cnt_d = edge_cnt_q;
        frame_d    = frame_q;
        data_oe_d  = data_oe_q;
        done_d     = 1'b0;
        ack_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                edge_cnt_d = 4'd0;
                data_oe_d  = 1'b0;
                if (send) begin
                    // Odd parity: the parity bit makes the total count of ones odd.
                    frame_d = {1'b1, ~^tx_byte, tx_byte};
                end
            end
            ST_INHIBIT: begin
                inh_cnt_d = inh_cnt_q + INH_W'(1);
                if (inhibit_last) begin
                    data_oe_d = 1'b1;
                end
            end
            ST_START: begin
                edge_cnt_d = 4'd0;
                data_oe_d  = 1'b1;
            end
            ST_SHIFT: begin
                if (fall) begin
                    // Edge n presents frame bit n-1; the line follows one cycle later.
                    edge_cnt_d = edge_cnt_inc;
                    data_oe_d  = ~frame_q[0];
                    frame_d    = {1'b1, frame_q[9:1]};
                end
            end
            ST_ACK: begin
                if (fall) begin
                    edge_cnt_d = edge_cnt_inc;
                    if (data_s2_q) begin
                        ack_err_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_WAIT_IDLE: data_oe_d = 1'b0;
            default:      data_oe_d = 1'b0;
        endcase
        if (timeout_hit) begin
            ack_err_d = 1'b1;
            done_d    = 1'b0;
            data_oe_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            inh_cnt_q  <= '0;
            edge_cnt_q <= 4'd0;
            frame_q    <= 10'd0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            inh_cnt_q  <= inh_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            frame_q    <= frame_d;
            data_oe_q  <= data_oe_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with a behavioural PS/2 device model.
// Build with +define+PS2_TX_TIMEOUT_EN to include the stall-timeout scenario.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 300;
    localparam int HALF = 10;

    logic       Clk;
    logic       Reset;
    logic       send;
    logic [7:0] tx_byte;
    logic       psClk_oe;
    logic       psData_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [2:0] state_dbg;

    // Device side of the open-drain lines (1 = released).
    logic dev_clk;
    logic dev_data;
    logic ps_clk_line;
    logic ps_data_line;

    assign ps_clk_line  = ~psClk_oe & dev_clk;
    assign ps_data_line = ~psData_oe & dev_data;

    int checks;
    int errors;

    // Pulse monitor counters.
    int   done_cycles, done_rises, err_cycles, err_rises, both_cycles;
    logic done_prev, err_prev;

    logic [9:0] exp_q[$];

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .send     (send),
        .tx_byte  (tx_byte),
        .psClk_in (ps_clk_line),
        .psData_in(ps_data_line),
        .psClk_oe (psClk_oe),
        .psData_oe(psData_oe),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- pulse monitor ----------------
    initial begin
        done_prev = 1'b0;
        err_prev  = 1'b0;
    end

    always @(negedge Clk) begin
        if (done === 1'b1) done_cycles++;
        if (ack_err === 1'b1) err_cycles++;
        if (done === 1'b1 && done_prev !== 1'b1) done_rises++;
        if (ack_err === 1'b1 && err_prev !== 1'b1) err_rises++;
        if (done === 1'b1 && ack_err === 1'b1) both_cycles++;
        done_prev = done;
        err_prev  = ack_err;
    end

    task automatic clear_mon();
        done_cycles = 0;
        done_rises  = 0;
        err_cycles  = 0;
        err_rises   = 0;
        both_cycles = 0;
    endtask

    // ---------------- reference model ----------------
    // Frame as it must appear on the data line for edges 1..10.
    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b};
    endfunction

    // ---------------- drivers ----------------
    task automatic do_send(input logic [7:0] b);
        tx_byte = b;
        send    = 1'b1;
        @(negedge Clk);
        send    = 1'b0;
    endtask

    // Device: watch the inhibit/start request, then clock n_edges bits in.
    // Optionally pulses send with another byte just after edge inject_at.
    task automatic dev_frame(input int n_edges, input bit do_ack, input int inject_at,
                             input logic [7:0] inject_byte, output logic [10:0] bits,
                             output int inh_cycles, output int overlap,
                             output logic start_oe, output bit timed_out);
        int guard;
        bits       = '0;
        inh_cycles = 0;
        overlap    = 0;
        start_oe   = 1'b0;
        timed_out  = 1'b0;
        guard      = 0;
        while (psClk_oe !== 1'b1 && guard < 100) begin
            @(negedge Clk);
            guard++;
        end
        if (psClk_oe !== 1'b1) begin
            timed_out = 1'b1;
            return;
        end
        while (psClk_oe === 1'b1 && inh_cycles < INH + 100) begin
            inh_cycles++;
            if (psData_oe === 1'b1) overlap++;
            @(negedge Clk);
        end
        start_oe = psData_oe;
        repeat (HALF) @(negedge Clk);
        for (int n = 1; n <= n_edges; n++) begin
            if (n == 11) begin
                dev_data = ~do_ack;
                repeat (HALF) @(negedge Clk);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge Clk);
            bits[n-1] = ps_data_line;
            dev_clk = 1'b1;
            if (n == inject_at) begin
                tx_byte = inject_byte;
                send    = 1'b1;
                @(negedge Clk);
                send    = 1'b0;
                repeat (HALF - 1) @(negedge Clk);
            end else begin
                repeat (HALF) @(negedge Clk);
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        int g;
        g = 0;
        while (busy !== 1'b0 && g < 1000) begin
            @(negedge Clk);
            g++;
        end
        ok = (busy === 1'b0);
    endtask

    // One complete frame through the device model, checked against the model.
    task automatic run_checked_frame(input logic [7:0] b, input bit ack, input int inject_at,
                                     input logic [7:0] inject_byte, input string name,
                                     output logic [10:0] bits);
        logic [9:0] exp;
        int         inh, ovl;
        logic       st;
        bit         to, idle_ok;
        clear_mon();
        exp_q.push_back(exp_frame(b));
        do_send(b);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_rise: busy=%b expected 1", name, busy);
        end
        dev_frame(11, ack, inject_at, inject_byte, bits, inh, ovl, st, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s_inhibit_seen: no clock inhibit within 100 cycles", name);
        end
        checks++;
        if (inh != INH) begin
            errors++;
            $display("FAIL %s_inhibit_len: got %0d cycles expected %0d", name, inh, INH);
        end
        checks++;
        if (ovl != 1) begin
            errors++;
            $display("FAIL %s_start_overlap: got %0d cycles expected 1", name, ovl);
        end
        checks++;
        if (st !== 1'b1) begin
            errors++;
            $display("FAIL %s_start_bit: psData_oe=%b expected 1", name, st);
        end
        exp = exp_q.pop_front();
        checks++;
        if (bits[9:0] !== exp) begin
            errors++;
            $display("FAIL %s_frame_bits: got %h expected %h", name, bits[9:0], exp);
        end
        if (ack) begin
            repeat (HALF) @(negedge Clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_busy_hold: busy=%b expected 1 while data held low", name, busy);
            end
        end
        dev_data = 1'b1;
        wait_idle(idle_ok);
        checks++;
        if (!idle_ok) begin
            errors++;
            $display("FAIL %s_busy_fall: busy=%b expected 0 after lines idle", name, busy);
        end
        checks++;
        if (done_rises != int'(ack) || done_cycles != int'(ack)) begin
            errors++;
            $display("FAIL %s_done: rises=%0d cycles=%0d expected %0d", name, done_rises, done_cycles, int'(ack));
        end
        checks++;
        if (err_rises != int'(!ack) || err_cycles != int'(!ack)) begin
            errors++;
            $display("FAIL %s_ack_err: rises=%0d cycles=%0d expected %0d", name, err_rises, err_cycles, int'(!ack));
        end
        checks++;
        if (both_cycles != 0) begin
            errors++;
            $display("FAIL %s_exclusive: done&ack_err for %0d cycles expected 0", name, both_cycles);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset    = 1'b0;
        send     = 1'b0;
        tx_byte  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if (psClk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b expected 0", psClk_oe); end
        checks++;
        if (psData_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b expected 0", psData_oe); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0 || ack_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: done=%b ack_err=%b expected 0 0", done, ack_err);
        end
        Reset = 1'b1;
        repeat (5) @(negedge Clk);
        checks++;
        if (busy !== 1'b0 || psClk_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b psClk_oe=%b expected 0 0", busy, psClk_oe);
        end
    endtask

    task automatic test_basic();
        logic [10:0] bits;
        run_checked_frame(8'hED, 1'b1, 0, 8'h00, "basic_ed", bits);
        checks++;
        if (bits[9:0] !== 10'h3ED) begin
            errors++;
            $display("FAIL basic_ed_literal: got %h expected 3ed", bits[9:0]);
        end
    endtask

    task automatic test_parity();
        logic [10:0] bits;
        run_checked_frame(8'h00, 1'b1, 0, 8'h00, "parity_00", bits);
        checks++;
        if (bits[8] !== 1'b1) begin errors++; $display("FAIL parity_00_bit: got %b expected 1", bits[8]); end
        run_checked_frame(8'h01, 1'b1, 0, 8'h00, "parity_01", bits);
        checks++;
        if (bits[8] !== 1'b0) begin errors++; $display("FAIL parity_01_bit: got %b expected 0", bits[8]); end
        for (int i = 0; i < 4; i++) begin
            run_checked_frame(8'($urandom_range(0, 255)), 1'b1, 0, 8'h00, "random", bits);
        end
    endtask

    task automatic test_nack();
        logic [10:0] bits;
        run_checked_frame(8'($urandom_range(0, 255)), 1'b0, 0, 8'h00, "nack", bits);
    endtask

    task automatic test_idle_edges();
        logic [10:0] bits;
        int          oe_cycles;
        oe_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) begin
                @(negedge Clk);
                if (psClk_oe !== 1'b0 || psData_oe !== 1'b0 || busy !== 1'b0) oe_cycles++;
            end
            dev_clk = 1'b1;
            repeat (HALF) @(negedge Clk);
        end
        checks++;
        if (oe_cycles != 0) begin
            errors++;
            $display("FAIL idle_edges_quiet: %0d active cycles expected 0", oe_cycles);
        end
        run_checked_frame(8'($urandom_range(0, 255)), 1'b1, 0, 8'h00, "after_idle_edges", bits);
    endtask

    task automatic test_send_during_shift();
        logic [10:0] bits;
        logic [7:0]  b, other;
        int          extra;
        b     = 8'($urandom_range(0, 255));
        other = b ^ 8'($urandom_range(1, 255));
        run_checked_frame(b, 1'b1, 4, other, "send_in_shift", bits);
        extra = 0;
        repeat (60) begin
            @(negedge Clk);
            if (psClk_oe === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL send_in_shift_no_queue: %0d busy cycles expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] bits;
        logic [7:0]  b;
        int          inh, ovl;
        logic        st;
        bit          to;
        b = 8'($urandom_range(0, 255)) & 8'hDF;   // bit 5 low: line driven low after edge 6
        clear_mon();
        do_send(b);
        dev_frame(5, 1'b1, 0, 8'h00, bits, inh, ovl, st, to);
        dev_clk = 1'b0;
        repeat (4) @(negedge Clk);
        checks++;
        if (psData_oe !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: psData_oe=%b busy=%b expected 1 1", psData_oe, busy);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (psClk_oe !== 1'b0 || psData_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: psClk_oe=%b psData_oe=%b expected 0 0", psClk_oe, psData_oe);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b expected 0", busy); end
        dev_clk = 1'b1;
        repeat (5) @(negedge Clk);
        Reset = 1'b1;
        repeat (5) @(negedge Clk);
        checks++;
        if (done_cycles != 0 || err_cycles != 0) begin
            errors++;
            $display("FAIL reset_mid_pulses: done=%0d ack_err=%0d expected 0 0", done_cycles, err_cycles);
        end
        run_checked_frame(8'($urandom_range(0, 255)), 1'b1, 0, 8'h00, "after_reset", bits);
    endtask

`ifdef PS2_TX_TIMEOUT_EN
    task automatic test_timeout();
        logic [10:0] bits;
        int          inh, ovl, k;
        logic        st;
        bit          to, idle_ok;
        clear_mon();
        do_send(8'($urandom_range(0, 255)));
        dev_frame(3, 1'b1, 0, 8'h00, bits, inh, ovl, st, to);
        dev_clk = 1'b0;   // 4th edge, then the device goes silent
        k = 0;
        while (ack_err !== 1'b1 && k < TMO + 100) begin
            @(negedge Clk);
            k++;
        end
        // Two synchronizer cycles, then TIMEOUT_CYCLES from the detected edge.
        checks++;
        if (k != TMO + 2) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d", k, TMO + 2);
        end
        checks++;
        if (psClk_oe !== 1'b0 || psData_oe !== 1'b0) begin
            errors++;
            $display("FAIL timeout_release: psClk_oe=%b psData_oe=%b expected 0 0", psClk_oe, psData_oe);
        end
        dev_clk = 1'b1;
        wait_idle(idle_ok);
        checks++;
        if (!idle_ok || err_rises != 1 || err_cycles != 1 || done_cycles != 0) begin
            errors++;
            $display("FAIL timeout_pulses: idle=%0d err_rises=%0d err_cycles=%0d done=%0d expected 1 1 1 0",
                     idle_ok, err_rises, err_cycles, done_cycles);
        end
    endtask
`endif

    // ---------------- sequence ----------------
    initial begin
        checks = 0;
        errors = 0;
        clear_mon();
        test_reset();
        test_basic();
        test_parity();
        test_nack();
        test_idle_edges();
        test_send_during_shift();
        test_reset_mid();
`ifdef PS2_TX_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
